bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Bit-serial system-bus master interface; sits directly upstream of the 2-master arbiter. One instance per master.
- Accepts a single read/write command from local master logic and raises BREQ. After BGRANT, it shifts address and write data onto the serial bus, or collects serial read data.
- Releases BREQ and returns a one-cycle response to local logic.

Parameters:
- ADDR_WIDTH, 12, serial address length in bits.
- DATA_WIDTH, 8, serial data length in bits.
- TIMEOUT_CYCLES, 16, read-wait limit; used only with BUS_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  local command valid
- req_ready  out  1  port idle, command accepted when req_valid & req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  completion with error; valid with rsp_valid
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid
- BREQ  out  1  bus request to arbiter
- BGRANT  in  1  bus grant from arbiter
- m_mode  out  1  latched req_write, driven while BREQ=1
- m_addr  out  1  serial address bit
- m_addr_valid  out  1  m_addr qualifier
- m_wdata  out  1  serial write data bit
- m_wdata_valid  out  1  m_wdata qualifier
- m_rdata  in  1  serial read data bit from slave
- m_rdata_valid  in  1  m_rdata qualifier

Behaviour:
- Reset (rstn=0 at posedge clk):
  - state=IDLE; counters and shift registers cleared.
  - BREQ, m_* outputs, rsp_valid, rsp_err and rsp_rdata are all 0; req_ready=1.
  - Reset mid-transaction aborts immediately with no response pulse.
- Output timing: all outputs are functions of registered state and registers only; no combinational input-to-output path.
- Serial order: all serial fields are LSB first, one bit per clk.
- IDLE:
  - req_ready=1, BREQ=0.
  - On req_valid=1, latch req_write/addr/wdata and go to REQ.
- REQ:
  - BREQ=1, req_ready=0.
  - Stay until BGRANT=1 is sampled, then go to ADDR. There is no timeout in REQ.
- ADDR:
  - m_addr_valid=1, m_addr=addr_reg[bit_cnt], bit_cnt 0..ADDR_WIDTH-1.
  - After bit ADDR_WIDTH-1, go to WDATA if write, else RWAIT. bit_cnt is cleared on each field change.
- WDATA:
  - m_wdata_valid=1, m_wdata=wdata_reg[bit_cnt].
  - After bit DATA_WIDTH-1, go to DONE with err=0.
- RWAIT:
  - Each cycle with m_rdata_valid=1 stores m_rdata into rdata_reg[bit_cnt] and increments bit_cnt.
  - After DATA_WIDTH valid bits, go to DONE with err=0. Gaps (valid=0) are allowed.
- Grant loss: BGRANT=0 sampled in ADDR, WDATA or RWAIT → DONE with err=1, rdata forced to 0. A simultaneous final bit and grant loss counts as error.
- DONE:
  - BREQ=0, rsp_valid=1 for exactly one cycle, rsp_err per cause.
  - rsp_rdata = assembled data (read, no error), else 0. Then go to IDLE.
- Other outputs: m_mode=write_reg while BREQ=1, else 0. BREQ=1 in REQ, ADDR, WDATA and RWAIT only.
- req_valid outside IDLE is ignored; the command is not queued.
- Minimum write transaction: 1 (REQ) + ADDR_WIDTH + DATA_WIDTH + 1 (DONE) cycles after acceptance.

Optional Feature:
- Macro: BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A counter in RWAIT counts consecutive cycles with m_rdata_valid=0 and clears on any valid bit.
  - When the counter reaches TIMEOUT_CYCLES → DONE with err=1, rdata 0.
- Undefined: no counter; RWAIT waits indefinitely (except grant loss).

Test Plan:
- Write addr=0xA5C, data=0x3C, BGRANT asserted 3 cycles after BREQ:
  - m_addr=0,0,1,1,1,0,1,0,0,1,0,1, then m_wdata=0,0,1,1,1,1,0,0.
  - rsp_valid=1, rsp_err=0, rsp_rdata=0x00; BREQ low in DONE.
- Read addr=0x001, slave sends 0x96 LSB first with 2 idle gaps → rsp_rdata=0x96, rsp_err=0, single rsp_valid pulse.
- Drop BGRANT while addr bit 5 is driven → next cycle DONE, rsp_err=1, rsp_rdata=0; BREQ=0; req_ready=1 the cycle after.
- With BUS_MASTER_TIMEOUT_EN, read with m_rdata_valid held 0 → rsp_err=1 exactly 16 RWAIT cycles after entry. Without the macro, the port is still in RWAIT after 100 cycles.
- rstn=0 during WDATA bit 3 → next cycle BREQ=0, m_wdata_valid=0, rsp_valid=0, req_ready=1.
- req_valid held high with two commands → second accepted only after DONE; req_ready=0 throughout the first transaction.

Source files
------------

// File: rtl/bus_master_port_if.sv
// Local command/response handshake and serial system-bus signals of one bus master port.
interface bus_master_port_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  BREQ;
  logic                  BGRANT;
  logic                  m_mode;
  logic                  m_addr;
  logic                  m_addr_valid;
  logic                  m_wdata;
  logic                  m_wdata_valid;
  logic                  m_rdata;
  logic                  m_rdata_valid;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, BGRANT, m_rdata, m_rdata_valid,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, BREQ, m_mode,
           m_addr, m_addr_valid, m_wdata, m_wdata_valid
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, BGRANT, m_rdata, m_rdata_valid,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, BREQ, m_mode,
           m_addr, m_addr_valid, m_wdata, m_wdata_valid
  );
endinterface

// File: rtl/bus_master_port.sv
// Bit-serial system-bus master port: takes one local command, requests the bus,
// shifts address/write data out LSB first or collects serial read data, then
// returns a one-cycle response. Optional read-wait timeout: BUS_MASTER_TIMEOUT_EN.
module bus_master_port #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rstn,
  bus_master_port_if.master bus
);
  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    WDATA,
    RWAIT,
    DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [DATA_WIDTH-1:0] wdata_sh;
  // Holds the read bits received so far; the final bit completes the word.
  logic [DATA_WIDTH-2:0] rdata_sh;
  logic [DATA_WIDTH-1:0] rdata_full_c;
  logic                  end_c;
  logic                  end_err_c;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_cnt;

  // Consecutive read-wait cycles without a valid data bit.
  always_ff @(posedge clk) begin
    if (!rstn || state != RWAIT || bus.m_rdata_valid) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TO_W'(1);
    end
  end
`endif

  if (ADDR_WIDTH < 2 || DATA_WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_master_port: unsupported parameter values");
  end

  // Decide whether the bus phase ends this cycle and whether it ends in error.
  always_comb begin
    end_c        = 1'b0;
    end_err_c    = 1'b0;
    rdata_full_c = {bus.m_rdata, rdata_sh};
    case (state)
      ADDR: begin
        if (!bus.BGRANT) begin
          end_c     = 1'b1;
          end_err_c = 1'b1;
        end
      end
      WDATA: begin
        if (!bus.BGRANT) begin
          end_c     = 1'b1;
          end_err_c = 1'b1;
        end else if (bit_cnt == DATA_LAST) begin
          end_c = 1'b1;
        end
      end
      RWAIT: begin
        if (!bus.BGRANT) begin
          end_c     = 1'b1;
          end_err_c = 1'b1;
        end else if (bus.m_rdata_valid && bit_cnt == DATA_LAST) begin
          end_c = 1'b1;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (!bus.m_rdata_valid && idle_cnt == TO_LAST) begin
          end_c     = 1'b1;
          end_err_c = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  // Command acceptance, serial sequencing and response generation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      write_reg         <= 1'b0;
      addr_sh           <= '0;
      wdata_sh          <= '0;
      rdata_sh          <= '0;
      bus.req_ready     <= 1'b1;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_err       <= 1'b0;
      bus.rsp_rdata     <= '0;
      bus.BREQ          <= 1'b0;
      bus.m_mode        <= 1'b0;
      bus.m_addr        <= 1'b0;
      bus.m_addr_valid  <= 1'b0;
      bus.m_wdata       <= 1'b0;
      bus.m_wdata_valid <= 1'b0;
    end else if (end_c) begin
      state             <= DONE;
      bit_cnt           <= '0;
      addr_sh           <= '0;
      wdata_sh          <= '0;
      rdata_sh          <= '0;
      bus.BREQ          <= 1'b0;
      bus.m_mode        <= 1'b0;
      bus.m_addr        <= 1'b0;
      bus.m_addr_valid  <= 1'b0;
      bus.m_wdata       <= 1'b0;
      bus.m_wdata_valid <= 1'b0;
      bus.rsp_valid     <= 1'b1;
      bus.rsp_err       <= end_err_c;
      bus.rsp_rdata     <= (!end_err_c && state == RWAIT) ? rdata_full_c : '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state         <= REQ;
            write_reg     <= bus.req_write;
            addr_sh       <= bus.req_addr;
            wdata_sh      <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            bus.BREQ      <= 1'b1;
            bus.m_mode    <= bus.req_write;
          end
        end
        REQ: begin
          if (bus.BGRANT) begin
            state            <= ADDR;
            bit_cnt          <= '0;
            bus.m_addr_valid <= 1'b1;
            bus.m_addr       <= addr_sh[0];
            addr_sh          <= addr_sh >> 1;
          end
        end
        ADDR: begin
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt          <= '0;
            bus.m_addr_valid <= 1'b0;
            bus.m_addr       <= 1'b0;
            if (write_reg) begin
              state             <= WDATA;
              bus.m_wdata_valid <= 1'b1;
              bus.m_wdata       <= wdata_sh[0];
              wdata_sh          <= wdata_sh >> 1;
            end else begin
              state <= RWAIT;
            end
          end else begin
            bit_cnt    <= bit_cnt + CNT_W'(1);
            bus.m_addr <= addr_sh[0];
            addr_sh    <= addr_sh >> 1;
          end
        end
        WDATA: begin
          bit_cnt     <= bit_cnt + CNT_W'(1);
          bus.m_wdata <= wdata_sh[0];
          wdata_sh    <= wdata_sh >> 1;
        end
        RWAIT: begin
          if (bus.m_rdata_valid) begin
            rdata_sh <= rdata_full_c[DATA_WIDTH-1:1];
            bit_cnt  <= bit_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: table vectors, hand-written corner sequences and
// randomized transactions checked against a transaction-level model.
module tb_bus_master_port;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            gdelay;     // REQ cycles with BGRANT low before the grant
    logic [15:0]   gap_mask;   // bit j set: no valid read bit in read-wait cycle j
    int            drop_k;     // bus-phase cycle with BGRANT low, -1 for none
    logic          hold_valid; // keep req_valid high (with other fields) during txn
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;

  bus_master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bus_master_port #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic gap_at(input logic [15:0] mask, input int j);
    logic [15:0] t;
    t = mask >> j;
    return (j < 16) ? t[0] : 1'b0;
  endfunction

  // Undisturbed bus-phase length: address bits, then write bits or the read
  // cycles needed to collect DW valid bits around the gaps.
  function automatic int bus_len(input logic wr, input logic [15:0] mask);
    int got = 0;
    int j   = 0;
    if (wr) return AW + DW;
    while (got < DW) begin
      if (!gap_at(mask, j)) got++;
      j++;
    end
    return AW + j;
  endfunction

  task automatic run_txn(input vec_t v);
    int            len;
    int            last;
    int            got;
    logic          rv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    len  = bus_len(v.wr, v.gap_mask);
    last = (v.drop_k >= 0 && v.drop_k < len) ? v.drop_k : len - 1;
    chk("idle_ready", 32'(bus.req_ready), 1);
    chk("idle_breq", 32'(bus.BREQ), 0);
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    tick();
    if (v.hold_valid) begin
      bus.req_write = ~v.wr;
      bus.req_addr  = ~v.addr;
      bus.req_wdata = ~v.wdata;
    end else begin
      bus.req_valid = 1'b0;
    end
    for (int i = 0; i <= v.gdelay; i++) begin
      chk("req_breq", 32'(bus.BREQ), 1);
      chk("req_ready_low", 32'(bus.req_ready), 0);
      chk("req_mode", 32'(bus.m_mode), 32'(v.wr));
      chk("req_addr_valid", 32'(bus.m_addr_valid), 0);
      bus.BGRANT = (i == v.gdelay);
      tick();
    end
    got = 0;
    for (int k = 0; k <= last; k++) begin
      if (k < int'(AW)) begin
        a = v.addr >> k;
        chk("m_addr_valid", 32'(bus.m_addr_valid), 1);
        chk("m_addr", 32'(bus.m_addr), 32'(a[0]));
        chk("addr_wdata_valid", 32'(bus.m_wdata_valid), 0);
      end else if (v.wr) begin
        d = v.wdata >> (k - int'(AW));
        chk("m_wdata_valid", 32'(bus.m_wdata_valid), 1);
        chk("m_wdata", 32'(bus.m_wdata), 32'(d[0]));
        chk("wdata_addr_valid", 32'(bus.m_addr_valid), 0);
      end else begin
        chk("rwait_addr_valid", 32'(bus.m_addr_valid), 0);
        chk("rwait_wdata_valid", 32'(bus.m_wdata_valid), 0);
      end
      chk("bus_breq", 32'(bus.BREQ), 1);
      chk("bus_mode", 32'(bus.m_mode), 32'(v.wr));
      chk("bus_ready_low", 32'(bus.req_ready), 0);
      chk("bus_rsp_low", 32'(bus.rsp_valid), 0);
      bus.BGRANT = (k != v.drop_k);
      rv = 1'b0;
      if (!v.wr && k >= int'(AW)) begin
        rv = !gap_at(v.gap_mask, k - int'(AW)) && got < int'(DW);
        d  = v.rdata >> got;
        bus.m_rdata = rv ? d[0] : 1'($urandom);
      end
      bus.m_rdata_valid = rv;
      tick();
      if (rv) got++;
    end
    bus.BGRANT        = 1'b0;
    bus.m_rdata_valid = 1'b0;
    bus.m_rdata       = 1'b0;
    chk("rsp_valid", 32'(bus.rsp_valid), 1);
    chk("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(v.exp_rdata));
    chk("done_breq", 32'(bus.BREQ), 0);
    chk("done_mode", 32'(bus.m_mode), 0);
    chk("done_ready_low", 32'(bus.req_ready), 0);
    chk("done_addr_valid", 32'(bus.m_addr_valid), 0);
    chk("done_wdata_valid", 32'(bus.m_wdata_valid), 0);
    tick();
    chk("post_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("post_ready", 32'(bus.req_ready), 1);
    chk("post_breq", 32'(bus.BREQ), 0);
  endtask

  // Accept a command with an immediate grant and walk to the first bus cycle.
  task automatic start_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
    bus.BGRANT    = 1'b1;
    tick();
  endtask

  vec_t vecs[9];
  vec_t v;
  int   len;
  int   n;
  logic seen;

  initial begin
    rstn              = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.BGRANT        = 1'b0;
    bus.m_rdata       = 1'b0;
    bus.m_rdata_valid = 1'b0;

    vecs[0] = '{1'b1, 12'hA5C, 8'h3C, 8'h00, 3, 16'h0000, -1, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 12'h001, 8'h00, 8'h96, 1, 16'h0024, -1, 1'b0, 1'b0, 8'h96};
    vecs[2] = '{1'b1, 12'h5A3, 8'hC3, 8'h00, 0, 16'h0000, 5, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 12'h7E1, 8'h00, 8'h5A, 2, 16'h0001, int'(AW) + 8, 1'b0, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 12'hFFF, 8'hFF, 8'h00, 0, 16'h0000, int'(AW + DW) - 1, 1'b0, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 12'h800, 8'h00, 8'h01, 0, 16'h0000, int'(AW) - 1, 1'b0, 1'b1, 8'h00};
    vecs[6] = '{1'b1, 12'h123, 8'hA5, 8'h00, 0, 16'h0000, -1, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 12'hFFF, 8'h00, 8'hFF, 0, 16'hAAAA, -1, 1'b0, 1'b0, 8'hFF};
    vecs[8] = '{1'b1, 12'h000, 8'h00, 8'h00, 1, 16'h0000, -1, 1'b0, 1'b0, 8'h00};

    // Reset state
    repeat (2) tick();
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_breq", 32'(bus.BREQ), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_mode", 32'(bus.m_mode), 0);
    chk("rst_addr_valid", 32'(bus.m_addr_valid), 0);
    chk("rst_wdata_valid", 32'(bus.m_wdata_valid), 0);
    rstn = 1'b1;
    tick();
    chk("idle_no_req_breq", 32'(bus.BREQ), 0);

    // Table vectors (entry 6 keeps req_valid high so entry 7 follows back-to-back)
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Reset during write data bit 3
    start_cmd(1'b1, 12'h3C3, 8'h08);
    repeat (AW + 3) tick();
    chk("pre_rst_wvalid", 32'(bus.m_wdata_valid), 1);
    chk("pre_rst_wbit3", 32'(bus.m_wdata), 1);
    rstn = 1'b0;
    tick();
    chk("midrst_breq", 32'(bus.BREQ), 0);
    chk("midrst_wvalid", 32'(bus.m_wdata_valid), 0);
    chk("midrst_rsp", 32'(bus.rsp_valid), 0);
    chk("midrst_ready", 32'(bus.req_ready), 1);
    rstn       = 1'b1;
    bus.BGRANT = 1'b0;
    seen       = 1'b0;
    repeat (3) begin
      tick();
      if (bus.rsp_valid || bus.BREQ) seen = 1'b1;
    end
    chk("midrst_quiet", 32'(seen), 0);

    // Read with no data ever arriving
    start_cmd(1'b0, 12'h0F0, 8'h00);
    repeat (AW) tick();
    chk("rwait_entry_breq", 32'(bus.BREQ), 1);
    chk("rwait_entry_addr_valid", 32'(bus.m_addr_valid), 0);
`ifdef BUS_MASTER_TIMEOUT_EN
    n    = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      bus.m_rdata = 1'($urandom);
      tick();
      if (bus.rsp_valid) begin
        seen = 1'b1;
        n    = i;
      end
    end
    chk("timeout_cycles", 32'(n), TO);
    chk("timeout_err", 32'(bus.rsp_err), 1);
    chk("timeout_rdata", 32'(bus.rsp_rdata), 0);
    chk("timeout_breq", 32'(bus.BREQ), 0);
    bus.BGRANT = 1'b0;
    tick();
    chk("timeout_post_ready", 32'(bus.req_ready), 1);
`else
    seen = 1'b0;
    repeat (100) begin
      bus.m_rdata = 1'($urandom);
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("no_timeout_rsp", 32'(seen), 0);
    chk("no_timeout_breq", 32'(bus.BREQ), 1);
    bus.BGRANT = 1'b0;
    tick();
    chk("stall_drop_rsp", 32'(bus.rsp_valid), 1);
    chk("stall_drop_err", 32'(bus.rsp_err), 1);
    chk("stall_drop_rdata", 32'(bus.rsp_rdata), 0);
    tick();
    chk("stall_post_ready", 32'(bus.req_ready), 1);
`endif

    // Randomized transactions against the transaction-level model
    for (int t = 0; t < 40; t++) begin
      v.wr         = 1'($urandom);
      v.addr       = AW'($urandom);
      v.wdata      = DW'($urandom);
      v.rdata      = DW'($urandom);
      v.gdelay     = int'($urandom_range(3, 0));
      v.gap_mask   = 16'($urandom & $urandom) & 16'h7FFF;
      v.hold_valid = ($urandom_range(4, 0) == 0);
      len          = bus_len(v.wr, v.gap_mask);
      v.drop_k     = ($urandom_range(3, 0) == 0) ? int'($urandom_range(32'(len - 1), 0)) : -1;
      v.exp_err    = (v.drop_k >= 0);
      v.exp_rdata  = (!v.wr && !v.exp_err) ? v.rdata : '0;
      run_txn(v);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("final_idle_ready", 32'(bus.req_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
